// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: shift-register scoreboard of post-decode instructions
// driving load-use stalls, redirect flushes, EX forwarding selects and the ID read bypass.
module hazard_scoreboard #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned FWD_W      = $clog2(STAGES),
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_ru_write,
  input  logic              id_is_load,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush_id,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic              id_byp_a,
  output logic              id_byp_b,
  output logic              ex_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned Wb = STAGES - 1;

  // Per-entry destination state; only the EX entry needs its source operands.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] wr_q;
  logic [STAGES-2:0] load_q;
  logic [REG_AW-1:0] rd_q [STAGES];
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic              use1_q;
  logic              use2_q;

  logic              lu_a;
  logic              lu_b;
  logic              hit_a;
  logic              hit_b;
  logic              take_id;

  // Youngest matching entry wins, so scan from oldest to youngest and let later hits override.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    lu_a  = 1'b0;
    lu_b  = 1'b0;
    for (int j = int'(STAGES) - 2; j >= 0; j--) begin
      if (valid_q[j] && wr_q[j] && id_valid) begin
        if (id_use_rs1 && (rd_q[j] == id_rs1)) begin
          hit_a = 1'b1;
          lu_a  = load_q[j] && (j + 1 < int'(LOAD_STAGE));
        end
        if (id_use_rs2 && (rd_q[j] == id_rs2)) begin
          hit_b = 1'b1;
          lu_b  = load_q[j] && (j + 1 < int'(LOAD_STAGE));
        end
      end
    end
    stall    = (lu_a || lu_b) && !br_taken;
    flush_id = br_taken && reset;
  end

  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = int'(STAGES) - 1; k >= 1; k--) begin
      if (valid_q[k] && wr_q[k]) begin
        if (use1_q && (rd_q[k] == rs1_q)) fwd_a = FWD_W'(k);
        if (use2_q && (rd_q[k] == rs2_q)) fwd_b = FWD_W'(k);
      end
    end
    if (!valid_q[0]) begin
      fwd_a = '0;
      fwd_b = '0;
    end
  end

  assign ex_valid = valid_q[0];
  assign id_byp_a = valid_q[Wb] && wr_q[Wb] && id_valid && id_use_rs1 && (rd_q[Wb] == id_rs1);
  assign id_byp_b = valid_q[Wb] && wr_q[Wb] && id_valid && id_use_rs2 && (rd_q[Wb] == id_rs2);
  assign take_id  = id_valid && !br_taken && !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      wr_q    <= '0;
      load_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      use1_q  <= 1'b0;
      use2_q  <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) rd_q[k] <= '0;
    end else begin
      valid_q <= {valid_q[STAGES-2:0], take_id};
      wr_q    <= {wr_q[STAGES-2:0], take_id && id_ru_write && (id_rd != '0)};
      for (int k = 1; k < int'(STAGES); k++) rd_q[k] <= rd_q[k-1];
      for (int k = 1; k < int'(STAGES) - 1; k++) load_q[k] <= load_q[k-1];
      load_q[0] <= take_id && id_is_load;
      rd_q[0]   <= take_id ? id_rd : '0;
      rs1_q     <= take_id ? id_rs1 : '0;
      rs2_q     <= take_id ? id_rs2 : '0;
      use1_q    <= take_id && id_use_rs1;
      use2_q    <= take_id && id_use_rs2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_id && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default 3-stage, a 4-stage/LOAD_STAGE=3 variant
// and a 4-bit-counter variant share the same ID stimulus.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2, id_ru_write, id_is_load, br_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        stall, flush_id, id_byp_a, id_byp_b, ex_valid;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        stall4, flush4, byp_a4, byp_b4, ex_valid4;
  logic [1:0]  fwd_a4, fwd_b4;
  logic [15:0] stall_cnt4, flush_cnt4;

  logic        stall_c, flush_c, byp_a_c, byp_b_c, ex_valid_c;
  logic [1:0]  fwd_a_c, fwd_b_c;
  logic [3:0]  stall_cnt_c, flush_cnt_c;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_ru_write(id_ru_write),
    .id_is_load(id_is_load), .br_taken(br_taken), .stall(stall), .flush_id(flush_id),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
    .ex_valid(ex_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_scoreboard #(.STAGES(4), .LOAD_STAGE(3)) dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_ru_write(id_ru_write),
    .id_is_load(id_is_load), .br_taken(br_taken), .stall(stall4), .flush_id(flush4),
    .fwd_a(fwd_a4), .fwd_b(fwd_b4), .id_byp_a(byp_a4), .id_byp_b(byp_b4),
    .ex_valid(ex_valid4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  hazard_scoreboard #(.CNT_W(4)) dutc (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_ru_write(id_ru_write),
    .id_is_load(id_is_load), .br_taken(br_taken), .stall(stall_c), .flush_id(flush_c),
    .fwd_a(fwd_a_c), .fwd_b(fwd_b_c), .id_byp_a(byp_a_c), .id_byp_b(byp_b_c),
    .ex_valid(ex_valid_c), .stall_cnt(stall_cnt_c), .flush_cnt(flush_cnt_c)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_ru_write = wr; id_is_load = ld;
  endtask

  task automatic nop_id;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; br_taken = 1'b0; nop_id();
    #2;
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_chk++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_exv: got %b want 0", ex_valid); end
    n_chk++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    @(negedge clk); reset = 1'b1;
    tick();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);        // lw x5,0(x1)
    tick();
    n_chk++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL rst_lw_exv: got %b want 1", ex_valid); end
    set_id(1, 5'd5, 5'd0, 1, 1, 5'd6, 1, 0);        // add x6,x5,x0
    #1;
    n_chk++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_pre_stall: got %b want 1", stall); end
    reset = 1'b0;
    #1;
    n_chk++; if (ex_valid !== 1'b0 || stall !== 1'b0 || fwd_a !== 2'd0) begin
      n_err++; $display("FAIL rst_async: got exv=%b stall=%b fwd_a=%0d want 0 0 0", ex_valid, stall, fwd_a); end
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);        // add x3,x1,x2
    #1; reset = 1'b1;
    tick();
    n_chk++; if (ex_valid !== 1'b1 || fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
      n_err++; $display("FAIL rst_release: got exv=%b fwd=%0d/%0d want 1 0/0", ex_valid, fwd_a, fwd_b); end
    n_chk++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_alu_fwd;
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);        // add x5,x1,x2
    tick();
    set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);        // sub x6,x5,x5
    #1;
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %b want 0", stall); end
    tick();
    n_chk++; if (fwd_a !== 2'd1 || fwd_b !== 2'd1) begin
      n_err++; $display("FAIL alu_fwd: got %0d/%0d want 1/1", fwd_a, fwd_b); end
  endtask

  task automatic test_dist2;
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);        // add x5
    tick(); nop_id(); tick();
    set_id(1, 5'd5, 5'd0, 1, 1, 5'd7, 1, 0);        // or x7,x5,x0
    #1;
    n_chk++; if (stall !== 1'b0 || id_byp_a !== 1'b0) begin
      n_err++; $display("FAIL d2_id: got stall=%b byp_a=%b want 0 0", stall, id_byp_a); end
    tick();
    n_chk++; if (fwd_a !== 2'd2 || fwd_b !== 2'd0) begin
      n_err++; $display("FAIL d2_fwd: got %0d/%0d want 2/0", fwd_a, fwd_b); end
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);        // add x5, then two nops
    tick(); nop_id(); tick(); tick();
    set_id(1, 5'd5, 5'd0, 1, 1, 5'd7, 1, 0);
    #1;
    n_chk++; if (id_byp_a !== 1'b1 || id_byp_b !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL wb_byp: got byp=%b/%b stall=%b want 1/0 0", id_byp_a, id_byp_b, stall); end
    tick();
    n_chk++; if (fwd_a !== 2'd0 || ex_valid !== 1'b1) begin
      n_err++; $display("FAIL wb_fwd: got fwd_a=%0d exv=%b want 0 1", fwd_a, ex_valid); end
  endtask

  task automatic test_load_use;
    nop_id(); tick(); tick(); tick();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);        // lw x5,0(x1)
    tick();
    set_id(1, 5'd5, 5'd0, 1, 1, 5'd6, 1, 0);        // add x6,x5,x0
    #1;
    n_chk++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall1: got %b want 1", stall); end
    tick();
    n_chk++; if (stall !== 1'b0 || stall_cnt !== 16'd1 || ex_valid !== 1'b0) begin
      n_err++; $display("FAIL lu_stall2: got stall=%b cnt=%0d exv=%b want 0 1 0", stall, stall_cnt, ex_valid); end
    tick();
    n_chk++; if (ex_valid !== 1'b1 || fwd_a !== 2'd2 || fwd_b !== 2'd0 || stall_cnt !== 16'd1) begin
      n_err++; $display("FAIL lu_ex: got exv=%b fwd=%0d/%0d cnt=%0d want 1 2/0 1",
                        ex_valid, fwd_a, fwd_b, stall_cnt); end
  endtask

  task automatic test_x0;
    nop_id(); tick();
    set_id(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0);        // addi x0,x0,1
    tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0);        // add x6,x0,x0
    #1;
    n_chk++; if (stall !== 1'b0 || id_byp_a !== 1'b0) begin
      n_err++; $display("FAIL x0_id: got stall=%b byp_a=%b want 0 0", stall, id_byp_a); end
    tick();
    n_chk++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0 || ex_valid !== 1'b1) begin
      n_err++; $display("FAIL x0_fwd: got fwd=%0d/%0d exv=%b want 0/0 1", fwd_a, fwd_b, ex_valid); end
  endtask

  task automatic test_branch;
    nop_id(); tick(); tick(); tick();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);        // lw x5
    tick();
    set_id(1, 5'd5, 5'd0, 1, 1, 5'd6, 1, 0);
    br_taken = 1'b1;
    #1;
    n_chk++; if (stall !== 1'b0 || flush_id !== 1'b1) begin
      n_err++; $display("FAIL br_prio: got stall=%b flush=%b want 0 1", stall, flush_id); end
    tick();
    br_taken = 1'b0;
    #1;
    n_chk++; if (ex_valid !== 1'b0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
      n_err++; $display("FAIL br_after: got exv=%b fcnt=%0d scnt=%0d want 0 1 1",
                        ex_valid, flush_cnt, stall_cnt); end
    nop_id(); tick();
  endtask

  task automatic test_load_use4;
    do_reset();
    n_chk++; if (stall_cnt4 !== 16'd0) begin n_err++; $display("FAIL lu4_rst: got %0d want 0", stall_cnt4); end
    nop_id(); tick();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
    tick();
    set_id(1, 5'd5, 5'd0, 1, 1, 5'd6, 1, 0);
    #1;
    n_chk++; if (stall4 !== 1'b1) begin n_err++; $display("FAIL lu4_s1: got %b want 1", stall4); end
    tick();
    n_chk++; if (stall4 !== 1'b1) begin n_err++; $display("FAIL lu4_s2: got %b want 1", stall4); end
    tick();
    n_chk++; if (stall4 !== 1'b0 || stall_cnt4 !== 16'd2) begin
      n_err++; $display("FAIL lu4_s3: got stall=%b cnt=%0d want 0 2", stall4, stall_cnt4); end
    tick();
    n_chk++; if (ex_valid4 !== 1'b1 || fwd_a4 !== 2'd3) begin
      n_err++; $display("FAIL lu4_ex: got exv=%b fwd_a=%0d want 1 3", ex_valid4, fwd_a4); end
  endtask

  task automatic test_saturation;
    do_reset();
    nop_id(); tick();
    for (int i = 0; i < 20; i++) begin
      set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
      tick();
      set_id(1, 5'd5, 5'd0, 1, 1, 5'd6, 1, 0);
      tick(); tick();
      if (i == 9) begin
        n_chk++; if (stall_cnt_c !== 4'd10 || stall_cnt !== 16'd10) begin
          n_err++; $display("FAIL sat_mid: got %0d/%0d want 10/10", stall_cnt_c, stall_cnt); end
      end
    end
    n_chk++; if (stall_cnt_c !== 4'd15) begin n_err++; $display("FAIL sat_hold: got %0d want 15", stall_cnt_c); end
    n_chk++; if (stall_cnt !== 16'd20) begin n_err++; $display("FAIL sat_wide: got %0d want 20", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_dist2();
    test_load_use();
    test_x0();
    test_branch();
    test_load_use4();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the pipelined successor of the single-cycle RISC-V datapath.
- Sits beside the decode stage. It tracks every in-flight instruction after decode in a shift-register scoreboard.
- Drives load-use stalls, branch flushes, EX-stage forwarding selects and the decode read bypass.
- Generalises to any post-decode depth and any load-result stage; it also keeps saturating stall and flush counters.

Parameters:
- REG_AW, 5, register address width.
- STAGES, 3, tracked post-decode stages (entry 0 = EX, entry STAGES-1 = WB); STAGES >= 2.
- LOAD_STAGE, 2, first entry index whose load result is forwardable; 1 <= LOAD_STAGE <= STAGES-1.
- FWD_W, $clog2(STAGES), forward-select width.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  ID source registers.
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2.
- id_rd  in  REG_AW  ID destination register.
- id_ru_write  in  1  ID instruction writes the register file.
- id_is_load  in  1  ID instruction is a load.
- br_taken  in  1  EX resolved a redirect (branch or jump) this cycle.
- stall  out  1  hold PC and the IF/ID register; insert a bubble into EX.
- flush_id  out  1  convert the IF/ID contents to a bubble.
- fwd_a, fwd_b  out  FWD_W  EX operand source: 0 = register-file value; k = result of entry k (1..STAGES-1).
- id_byp_a, id_byp_b  out  1  ID read must take the WB write data (same-cycle write/read).
- ex_valid  out  1  entry 0 holds a real instruction.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Entry fields: valid, rd, wr, load, rs1, rs2, use1, use2.
- wr is set only when id_ru_write=1 and id_rd != 0; x0 never produces a hazard.
- Reset (reset=0, asynchronous): all entries cleared to bubbles (valid=0, wr=0), counters 0.
- Combinational outputs therefore read during reset: stall=0, flush_id=0, fwd_a=fwd_b=0, id_byp_a=id_byp_b=0, ex_valid=0.
- Match at ID: entry j (0..STAGES-2) matches operand r when valid & wr & rd==id_r & use_r & id_valid.
- Youngest entry (lowest j) wins; entry STAGES-1 is excluded from the stall check.
- Load-use stall: stall=1 iff the winning match for either operand is a load with j+1 < LOAD_STAGE.
  - The stall self-clears as bubbles age the load forward.
  - Stall length is LOAD_STAGE-1-j cycles.
- Branch priority: br_taken=1 forces flush_id=1 and stall=0, whatever the ID hazards.
- Clock edge, shift: entry k <= entry k-1 for k >= 1; this happens every cycle, with no freeze.
- Clock edge, entry 0:
  - If br_taken or stall or !id_valid: bubble.
  - Otherwise: the ID fields.
- Forwarding (combinational, for the EX instruction in entry 0):
  - fwd_a = smallest k in 1..STAGES-1 with entry k valid & wr & rd==entry0.rs1 & entry0.use1; otherwise 0.
  - fwd_b is the same using rs2/use2.
  - Both forced to 0 when entry 0 is a bubble.
- Guarantee: a load never appears in a forwarding entry k < LOAD_STAGE against a dependent EX instruction, because the stall prevents it.
- Bypass: id_byp_a=1 iff entry STAGES-1 is valid & wr & rd==id_rs1 & id_use_rs1 & id_valid; id_byp_b is the same for rs2.
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - flush_cnt increments on each cycle with flush_id=1.
  - Both saturate at all-ones with no wrap.
- Mid-operation reset clears the scoreboard immediately, with no clock edge required.
- The first edge after reset release loads entry 0 normally.

Test Plan:
- Reset: assert reset=0 mid-stream with a load in EX → ex_valid=0, stall=0, fwd=0 at once; after release, `add x3,x1,x2` in ID enters EX next cycle with fwd_a=fwd_b=0.
- ALU→ALU forwarding: `add x5,x1,x2` then `sub x6,x5,x5` → no stall; when sub is in EX, fwd_a=fwd_b=1.
- Distance-2 forwarding: add x5 then nop then `or x7,x5,x0` → fwd_a=2 in EX; WB distance gives id_byp_a=1 in ID instead.
- Load-use (STAGES=3, LOAD_STAGE=2): `lw x5,0(x1)` then `add x6,x5,x0` → exactly one stall cycle, stall_cnt=1; add reaches EX with fwd_a=2.
- Load-use with LOAD_STAGE=3 (STAGES=4) → two stall cycles.
- Branch over stall: load in EX, dependent add in ID, br_taken=1 the same cycle → stall=0, flush_id=1, EX gets a bubble, flush_cnt=1.
- x0 and saturation:
  - `addi x0,x0,1` then `add x6,x0,x0` → no forward, no stall.
  - Preload stall_cnt near max (CNT_W=4): 20 stall cycles → stall_cnt holds at 15.
